// File: rtl/fetch_ctrl_pkg.sv
// Shared types and mux/flush encodings for the fetch stage controller
// and the PC mux / FetchDecode register it drives.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_SQUASH   = 3'd3,
    ST_STALL    = 3'd4,
    ST_HALT     = 3'd5
  } fetch_state_e;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] NOP_RUN       = 2'b00;
  localparam logic [1:0] NOP_HOLD      = 2'b01;
  localparam logic [1:0] FLUSH_NONE    = 2'b00;
  localparam logic [1:0] FLUSH_ON      = 2'b01;

  // Wide enough for the largest legal branch penalty (15).
  localparam int SQ_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the fetch performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_control_unit.sv
// Fetch stage sequencer: arbitrates branch redirects, halts and load-use
// stalls into PC-mux select, PC/IF-ID hold and IF-ID flush controls.
//
// state    | meaning
// INIT     | one flush cycle covering invalid ROM output after reset/halt
// RUN      | sequential fetch
// REDIRECT | PC mux selects latched branch target, IF-ID flushed
// SQUASH   | remaining branch-penalty flush cycles
// STALL    | load-use hazard, PC and IF-ID held
// HALT     | fetch frozen, IF-ID flushed
module fetch_control_unit
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall_req,
  input  logic              halt_req,
  output logic [1:0]        select_pc_mux,
  output logic [ADDR_W-1:0] branch_address,
  output logic [1:0]        select_nop_mux,
  output logic [1:0]        flush,
  output logic              fetch_busy,
  output logic [CNT_W-1:0]  redirect_count,
  output logic [CNT_W-1:0]  stall_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [SQ_W-1:0]   sq_q, sq_d;

  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    sq_d    = sq_q;
    unique case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (branch_taken) begin
          state_d = ST_REDIRECT;
          baddr_d = branch_target;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (stall_req) begin
          state_d = ST_STALL;
        end
      end
      ST_REDIRECT: begin
        if (BRANCH_PENALTY == 1) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SQUASH;
          sq_d    = SQ_W'(BRANCH_PENALTY - 1);
        end
      end
      ST_SQUASH: begin
        // Stall/halt stay pending and are picked up again from RUN.
        sq_d = sq_q - SQ_W'(1);
        if (branch_taken) begin
          state_d = ST_REDIRECT;
          baddr_d = branch_target;
        end else if (sq_q <= SQ_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_STALL: begin
        if (branch_taken) begin
          state_d = ST_REDIRECT;
          baddr_d = branch_target;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (!stall_req) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (branch_taken) begin
          state_d = ST_REDIRECT;
          baddr_d = branch_target;
        end else if (!halt_req) begin
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      baddr_q <= '0;
      sq_q    <= '0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      sq_q    <= sq_d;
    end
  end

  always_comb begin
    select_pc_mux  = PC_SEL_SEQ;
    select_nop_mux = NOP_RUN;
    flush          = FLUSH_NONE;
    unique case (state_q)
      ST_INIT:     flush = FLUSH_ON;
      ST_RUN:      ;
      ST_REDIRECT: begin
        select_pc_mux = PC_SEL_BRANCH;
        flush         = FLUSH_ON;
      end
      ST_SQUASH:   flush = FLUSH_ON;
      ST_STALL:    select_nop_mux = NOP_HOLD;
      ST_HALT: begin
        select_nop_mux = NOP_HOLD;
        flush          = FLUSH_ON;
      end
      default:     flush = FLUSH_ON;
    endcase
  end

  assign branch_address = baddr_q;
  assign fetch_busy     = (state_q != ST_RUN);

  // REDIRECT is never held across cycles, so every entry is a fresh redirect.
  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_d == ST_REDIRECT),
    .count (redirect_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q == ST_STALL),
    .count (stall_count)
  );

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed vector bench for fetch_control_unit (4-bit counters so saturation is reachable).
module tb_fetch_control_unit;

  localparam int AW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          stall_req;
  logic          halt_req;
  logic [1:0]    select_pc_mux;
  logic [AW-1:0] branch_address;
  logic [1:0]    select_nop_mux;
  logic [1:0]    flush;
  logic          fetch_busy;
  logic [CW-1:0] redirect_count;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_control_unit #(
    .ADDR_W(AW), .BRANCH_PENALTY(2), .CNT_W(CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall_req      (stall_req),
    .halt_req       (halt_req),
    .select_pc_mux  (select_pc_mux),
    .branch_address (branch_address),
    .select_nop_mux (select_nop_mux),
    .flush          (flush),
    .fetch_busy     (fetch_busy),
    .redirect_count (redirect_count),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          bt;
    logic [AW-1:0] tgt;
    logic          st;
    logic          ht;
    logic [1:0]    pc;
    logic [1:0]    nop;
    logic [1:0]    fl;
    logic          busy;
    logic [AW-1:0] ba;
    logic [CW-1:0] rc;
    logic [CW-1:0] sc;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic bt, input logic [AW-1:0] tgt, input logic st,
                              input logic ht, input logic [1:0] pc, input logic [1:0] nop,
                              input logic [1:0] fl, input logic busy, input logic [AW-1:0] ba,
                              input logic [CW-1:0] rc, input logic [CW-1:0] sc);
    vec_t v;
    v.bt = bt; v.tgt = tgt; v.st = st; v.ht = ht;
    v.pc = pc; v.nop = nop; v.fl = fl; v.busy = busy;
    v.ba = ba; v.rc = rc; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [1:0] pc, input logic [1:0] nop,
                         input logic [1:0] fl, input logic busy, input logic [AW-1:0] ba,
                         input logic [CW-1:0] rc, input logic [CW-1:0] sc);
    chk("select_pc_mux", idx, 32'(select_pc_mux), 32'(pc));
    chk("select_nop_mux", idx, 32'(select_nop_mux), 32'(nop));
    chk("flush", idx, 32'(flush), 32'(fl));
    chk("fetch_busy", idx, 32'(fetch_busy), 32'(busy));
    chk("branch_address", idx, 32'(branch_address), 32'(ba));
    chk("redirect_count", idx, 32'(redirect_count), 32'(rc));
    chk("stall_count", idx, 32'(stall_count), 32'(sc));
  endtask

  task automatic drive(input logic bt, input logic [AW-1:0] tgt, input logic st, input logic ht);
    branch_taken  = bt;
    branch_target = tgt;
    stall_req     = st;
    halt_req      = ht;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            bt tgt      st ht  pc     nop    fl    busy ba       rc  sc
    vecs[0]  = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'h0000, 0, 0); // INIT->RUN
    vecs[1]  = mk(1, 16'h0040, 0, 0, 2'b01, 2'b00, 2'b01, 1, 16'h0040, 1, 0); // REDIRECT
    vecs[2]  = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b01, 1, 16'h0040, 1, 0); // SQUASH
    vecs[3]  = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'h0040, 1, 0); // RUN
    vecs[4]  = mk(0, 16'h0000, 1, 0, 2'b00, 2'b01, 2'b00, 1, 16'h0040, 1, 0); // STALL
    vecs[5]  = mk(0, 16'h0000, 1, 0, 2'b00, 2'b01, 2'b00, 1, 16'h0040, 1, 1);
    vecs[6]  = mk(0, 16'h0000, 1, 0, 2'b00, 2'b01, 2'b00, 1, 16'h0040, 1, 2);
    vecs[7]  = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'h0040, 1, 3); // RUN
    vecs[8]  = mk(1, 16'h0100, 1, 0, 2'b01, 2'b00, 2'b01, 1, 16'h0100, 2, 3); // branch beats stall
    vecs[9]  = mk(0, 16'h0000, 1, 0, 2'b00, 2'b00, 2'b01, 1, 16'h0100, 2, 3); // SQUASH
    vecs[10] = mk(0, 16'h0000, 1, 0, 2'b00, 2'b00, 2'b00, 0, 16'h0100, 2, 3); // RUN
    vecs[11] = mk(0, 16'h0000, 1, 0, 2'b00, 2'b01, 2'b00, 1, 16'h0100, 2, 3); // STALL
    vecs[12] = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'h0100, 2, 4); // RUN
    vecs[13] = mk(1, 16'h0300, 0, 0, 2'b01, 2'b00, 2'b01, 1, 16'h0300, 3, 4); // REDIRECT
    vecs[14] = mk(1, 16'hDEAD, 0, 0, 2'b00, 2'b00, 2'b01, 1, 16'h0300, 3, 4); // ignored in REDIRECT
    vecs[15] = mk(1, 16'h0200, 0, 0, 2'b01, 2'b00, 2'b01, 1, 16'h0200, 4, 4); // re-redirect from SQUASH
    vecs[16] = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b01, 1, 16'h0200, 4, 4);
    vecs[17] = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'h0200, 4, 4);
    vecs[18] = mk(0, 16'h0000, 0, 1, 2'b00, 2'b01, 2'b01, 1, 16'h0200, 4, 4); // HALT
    vecs[19] = mk(0, 16'h0000, 0, 1, 2'b00, 2'b01, 2'b01, 1, 16'h0200, 4, 4);
    vecs[20] = mk(0, 16'h0000, 0, 1, 2'b00, 2'b01, 2'b01, 1, 16'h0200, 4, 4);
    vecs[21] = mk(0, 16'h0000, 0, 1, 2'b00, 2'b01, 2'b01, 1, 16'h0200, 4, 4);
    vecs[22] = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b01, 1, 16'h0200, 4, 4); // INIT
    vecs[23] = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'h0200, 4, 4); // RUN
    vecs[24] = mk(0, 16'h0000, 1, 1, 2'b00, 2'b01, 2'b01, 1, 16'h0200, 4, 4); // halt beats stall
    vecs[25] = mk(1, 16'h1234, 0, 1, 2'b01, 2'b00, 2'b01, 1, 16'h1234, 5, 4); // branch leaves HALT
    vecs[26] = mk(0, 16'h0000, 0, 1, 2'b00, 2'b00, 2'b01, 1, 16'h1234, 5, 4); // SQUASH ignores halt
    vecs[27] = mk(0, 16'h0000, 0, 1, 2'b00, 2'b00, 2'b00, 0, 16'h1234, 5, 4); // RUN
    vecs[28] = mk(0, 16'h0000, 0, 1, 2'b00, 2'b01, 2'b01, 1, 16'h1234, 5, 4); // HALT
    vecs[29] = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b01, 1, 16'h1234, 5, 4); // INIT
    vecs[30] = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'h1234, 5, 4); // RUN
    vecs[31] = mk(0, 16'h0000, 1, 0, 2'b00, 2'b01, 2'b00, 1, 16'h1234, 5, 4); // STALL
    vecs[32] = mk(0, 16'h0000, 1, 1, 2'b00, 2'b01, 2'b01, 1, 16'h1234, 5, 5); // STALL->HALT
    vecs[33] = mk(0, 16'h0000, 0, 0, 2'b00, 2'b00, 2'b01, 1, 16'h1234, 5, 5); // INIT
    vecs[34] = mk(1, 16'h5555, 0, 0, 2'b00, 2'b00, 2'b00, 0, 16'h1234, 5, 5); // INIT ignores branch

    reset = 1'b0;
    drive(0, '0, 0, 0);
    #12;
    chk_all(-1, 2'b00, 2'b00, 2'b01, 1'b1, 16'h0000, 0, 0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].bt, vecs[i].tgt, vecs[i].st, vecs[i].ht);
      step();
      chk_all(i, vecs[i].pc, vecs[i].nop, vecs[i].fl, vecs[i].busy, vecs[i].ba, vecs[i].rc, vecs[i].sc);
      @(negedge clk);
    end

    // Asynchronous reset while in SQUASH.
    drive(1, 16'h0777, 0, 0);
    step();
    chk_all(100, 2'b01, 2'b00, 2'b01, 1'b1, 16'h0777, 6, 5);
    @(negedge clk);
    drive(0, '0, 0, 0);
    step();
    chk_all(101, 2'b00, 2'b00, 2'b01, 1'b1, 16'h0777, 6, 5);
    #2;
    reset = 1'b0;
    #1;
    chk_all(102, 2'b00, 2'b00, 2'b01, 1'b1, 16'h0000, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_all(103, 2'b00, 2'b00, 2'b00, 1'b0, 16'h0000, 0, 0);

    // Stall counter saturation.
    @(negedge clk);
    drive(0, '0, 1, 0);
    repeat (20) step();
    chk_all(104, 2'b00, 2'b01, 2'b00, 1'b1, 16'h0000, 0, 15);
    @(negedge clk);
    drive(0, '0, 0, 0);
    step();
    chk_all(105, 2'b00, 2'b00, 2'b00, 1'b0, 16'h0000, 0, 15);

    // Redirect counter saturation.
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      drive(1, AW'(k * 16), 0, 0);
      step();
      @(negedge clk);
      drive(0, '0, 0, 0);
      step();
      step();
    end
    chk_all(106, 2'b00, 2'b00, 2'b00, 1'b0, 16'h0110, 15, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
